// File: rtl/piso_serializer.sv
// Purpose : parallel-in/serial-out transmitter, WIDTH-bit words shifted out LSB first, one bit per clock.
// Latency : word accepted at edge N puts bit k on serialOut during cycle N+1+k; back-to-back words leave no gap.
// Backpr. : dataReady is high in IDLE and during the last bit of a frame; dataIn/dataValid ignored otherwise.
// Option  : define PISO_PARITY_EN to append an even-parity bit after bit WIDTH-1 (frame becomes WIDTH+1 bits).
module piso_serializer #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             dataValid,
    output logic             dataReady,
    output logic             serialOut,
    output logic             frameStart,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CNT_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             ser_q, ser_d;
    logic             fs_q, fs_d;
    logic             busy_q, busy_d;
    logic             rdy_q, rdy_d;

    logic             accept;
    logic             word_parity;
    logic [WIDTH-1:0] load_word;
    logic [CNT_W-1:0] bit_cnt_inc;

`ifdef PISO_PARITY_EN
    assign word_parity = ^dataIn;
`else
    assign word_parity = 1'b0;
`endif

    // Bit 0 goes straight onto the line at load; the register keeps the remaining
    // data bits with the parity bit (or a filler zero) parked on top so it falls out last.
    assign load_word   = {word_parity, dataIn[WIDTH-1:1]};
    assign accept      = rdy_q && dataValid;
    assign bit_cnt_inc = bit_cnt_q + CNT_W'(1);

    // State and output registers; reset dominates and aborts any frame in flight.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ser_q     <= IDLE_LEVEL;
            fs_q      <= 1'b0;
            busy_q    <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ser_q     <= ser_d;
            fs_q      <= fs_d;
            busy_q    <= busy_d;
            rdy_q     <= rdy_d;
        end
    end

    // Next-state and next-output logic; a word accepted on the last bit reloads seamlessly.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ser_d     = ser_q;
        fs_d      = 1'b0;
        busy_d    = busy_q;
        rdy_d     = rdy_q;

        case (state_q)
            IDLE: begin
                ser_d  = IDLE_LEVEL;
                busy_d = 1'b0;
                rdy_d  = 1'b1;
                if (accept) begin
                    state_d   = SHIFT;
                    shift_d   = load_word;
                    ser_d     = dataIn[0];
                    fs_d      = 1'b1;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    rdy_d     = 1'b0;
                end
            end
            SHIFT: begin
                if (bit_cnt_q == LAST_CNT) begin
                    if (accept) begin
                        state_d   = SHIFT;
                        shift_d   = load_word;
                        ser_d     = dataIn[0];
                        fs_d      = 1'b1;
                        busy_d    = 1'b1;
                        bit_cnt_d = '0;
                        rdy_d     = 1'b0;
                    end else begin
                        state_d   = IDLE;
                        ser_d     = IDLE_LEVEL;
                        busy_d    = 1'b0;
                        bit_cnt_d = '0;
                        rdy_d     = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_inc;
                    ser_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                    busy_d    = 1'b1;
                    rdy_d     = (bit_cnt_inc == LAST_CNT);
                end
            end
            default: begin
                state_d   = IDLE;
                ser_d     = IDLE_LEVEL;
                busy_d    = 1'b0;
                bit_cnt_d = '0;
                rdy_d     = 1'b0;
            end
        endcase
    end

    assign dataReady  = rdy_q;
    assign serialOut  = ser_q;
    assign frameStart = fs_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: constant vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based model of the serial line.
module tb_piso_serializer;

    localparam int   WIDTH = 8;
    localparam logic IDLE  = 1'b0;
`ifdef PISO_PARITY_EN
    localparam int L = WIDTH + 1;
`else
    localparam int L = WIDTH;
`endif

    logic             clock;
    logic             resetN;
    logic [WIDTH-1:0] dataIn;
    logic             dataValid;
    logic             dataReady;
    logic             serialOut;
    logic             frameStart;
    logic             busy;

    int checks = 0;
    int errors = 0;

    // Model: bits still due on the line, each entry {frameStart, bit}.
    logic [1:0] line_q[$];
    logic m_ser  = IDLE;
    logic m_fs   = 1'b0;
    logic m_busy = 1'b0;
    logic m_rdy  = 1'b0;

    typedef struct {
        logic             rstn;
        logic             vld;
        logic [WIDTH-1:0] dat;
        logic             ser;
        logic             fs;
        logic             bsy;
        logic             rdy;
    } vec_t;

    vec_t vecs[$];

    piso_serializer #(.WIDTH(WIDTH), .IDLE_LEVEL(IDLE)) dut (
        .clock      (clock),
        .resetN     (resetN),
        .dataIn     (dataIn),
        .dataValid  (dataValid),
        .dataReady  (dataReady),
        .serialOut  (serialOut),
        .frameStart (frameStart),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare all outputs.
    task automatic step(input logic rst_v, input logic vld_v, input logic [WIDTH-1:0] d_v,
                        output logic acc);
        logic [1:0] e;
        resetN    = rst_v;
        dataValid = vld_v;
        dataIn    = d_v;
        @(posedge clock);
        #1;
        acc = 1'b0;
        if (!rst_v) begin
            line_q.delete();
            m_ser  = IDLE;
            m_fs   = 1'b0;
            m_busy = 1'b0;
            m_rdy  = 1'b0;
        end else begin
            if (m_rdy && vld_v) begin
                acc = 1'b1;
                for (int i = 0; i < WIDTH; i++) line_q.push_back({(i == 0), d_v[i]});
`ifdef PISO_PARITY_EN
                line_q.push_back({1'b0, ^d_v});
`endif
            end
            if (line_q.size() > 0) begin
                e      = line_q.pop_front();
                m_ser  = e[0];
                m_fs   = e[1];
                m_busy = 1'b1;
            end else begin
                m_ser  = IDLE;
                m_fs   = 1'b0;
                m_busy = 1'b0;
            end
            m_rdy = (line_q.size() == 0);
        end
        check("mdl_serialOut",  serialOut,  m_ser);
        check("mdl_frameStart", frameStart, m_fs);
        check("mdl_busy",       busy,       m_busy);
        check("mdl_dataReady",  dataReady,  m_rdy);
    endtask

    initial begin
        logic             acc;
        logic [WIDTH-1:0] words[3];
        logic [WIDTH-1:0] rd;
        int               k;
        int               cyc;
        int               busy_cnt;
        logic             any_acc;

        resetN    = 1'b0;
        dataValid = 1'b0;
        dataIn    = '0;

        // Reset held 3 cycles with dataValid high, release, then 8'hA5 on its own.
        vecs.push_back(vec_t'{1'b0, 1'b1, 8'hFF, IDLE, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 8'hFF, IDLE, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 8'hFF, IDLE, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 8'hA5, IDLE, 1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
`ifdef PISO_PARITY_EN
        vecs.push_back(vec_t'{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1});
`else
        vecs.push_back(vec_t'{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1});
`endif
        vecs.push_back(vec_t'{1'b1, 1'b0, 8'h00, IDLE, 1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b0, 8'h00, IDLE, 1'b0, 1'b0, 1'b1});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rstn, vecs[i].vld, vecs[i].dat, acc);
            check($sformatf("vec%0d_serialOut", i),  serialOut,  vecs[i].ser);
            check($sformatf("vec%0d_frameStart", i), frameStart, vecs[i].fs);
            check($sformatf("vec%0d_busy", i),       busy,       vecs[i].bsy);
            check($sformatf("vec%0d_dataReady", i),  dataReady,  vecs[i].rdy);
        end

        // Streaming three words with dataValid held high: no gaps between frames.
        words[0] = 8'h01;
        words[1] = 8'h80;
        words[2] = 8'hFF;
        k   = 0;
        cyc = 0;
        for (int s = 0; s < 3 * L + 1; s++) begin
            step(1'b1, (k < 3), (k < 3) ? words[k] : '0, acc);
            if (acc) k++;
            if (cyc > 0) cyc++;
            else if (acc) cyc = 1;
            if (cyc > 0) begin
                check($sformatf("strm_fs_c%0d", cyc), frameStart,
                      (cyc == 1 || cyc == L + 1 || cyc == 2 * L + 1));
                check($sformatf("strm_rdy_c%0d", cyc), dataReady,
                      ((cyc % L) == 0) || (cyc > 3 * L));
                check($sformatf("strm_busy_c%0d", cyc), busy, (cyc <= 3 * L));
            end
        end
        check("strm_words_taken", k, 3);

        // dataValid pulsed while bitCnt==3 must be ignored.
        step(1'b1, 1'b0, '0, acc);
        step(1'b1, 1'b1, 8'h3C, acc);
        check("pulse_first_accept", acc, 1'b1);
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        any_acc  = 1'b0;
        for (int s = 0; s < L + 2; s++) begin
            step(1'b1, (s == 3), (s == 3) ? 8'hFF : 8'h00, acc);
            any_acc = any_acc | acc;
            if (busy === 1'b1) busy_cnt++;
        end
        check("pulse_ignored", any_acc, 1'b0);
        check("pulse_busy_len", busy_cnt, L);

        // Reset at bitCnt==4 of 8'hC3 aborts the frame; next word starts at bit 0.
        step(1'b1, 1'b1, 8'hC3, acc);
        check("abort_accept", acc, 1'b1);
        for (int s = 0; s < 4; s++) step(1'b1, 1'b0, '0, acc);
        check("abort_bit4", serialOut, 1'b0);
        step(1'b0, 1'b1, 8'hFF, acc);
        check("abort_line_idle", serialOut, IDLE);
        check("abort_busy", busy, 1'b0);
        step(1'b1, 1'b1, 8'h5A, acc);
        check("abort_rdy_back", dataReady, 1'b1);
        step(1'b1, 1'b1, 8'h5A, acc);
        check("abort_new_bit0", serialOut, 1'b0);
        check("abort_new_fs", frameStart, 1'b1);
        for (int s = 0; s < L + 1; s++) step(1'b1, 1'b0, '0, acc);

`ifdef PISO_PARITY_EN
        // Parity frames: 8'h07 -> parity 1, 8'h03 -> parity 0, 9-cycle frames.
        words[0] = 8'h07;
        words[1] = 8'h03;
        k   = 0;
        cyc = 0;
        for (int s = 0; s < 2 * L + 1; s++) begin
            step(1'b1, (k < 2), (k < 2) ? words[k] : '0, acc);
            if (acc) k++;
            if (cyc > 0) cyc++;
            else if (acc) cyc = 1;
            if (cyc == 9)  check("par_bit_07", serialOut, 1'b1);
            if (cyc == 18) check("par_bit_03", serialOut, 1'b0);
            if (cyc > 0) check($sformatf("par_fs_c%0d", cyc), frameStart, (cyc == 1 || cyc == 10));
        end
`endif

        // Randomized traffic with occasional resets, checked by the model inside step().
        for (int s = 0; s < 3000; s++) begin
            rd = WIDTH'($urandom);
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0), rd, acc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
